// File: rtl/uart_tx_arb_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encodings and the
// default byte width agreed with the transmitter.
package uart_tx_arb_pkg;

    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_LOCK = 1'b1
    } arb_state_e;

    localparam int DATA_BITS_DEF = 8;

endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// Combinational round-robin picker: first set request bit strictly after
// ptr_i, wrapping modulo N. Returns one-hot winner and its index.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  win_o,
    output logic [IW-1:0] win_idx_o
);

    logic          found;
    logic [IW-1:0] cand;

    always_comb begin
        win_o     = '0;
        win_idx_o = '0;
        found     = 1'b0;
        cand      = '0;
        // ptr_i itself is scanned last, so the previous owner has lowest priority
        for (int k = 1; k <= N; k++) begin
            cand = IW'((int'(ptr_i) + k) % N);
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                win_o[cand] = 1'b1;
                win_idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Message-granular round-robin arbiter in front of a single UART transmitter.
// A grant is held until a last byte, MAX_LEN bytes, or an idle timeout.
module uart_tx_arb
    import uart_tx_arb_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int DATA_BITS    = DATA_BITS_DEF,
    parameter int MAX_LEN      = 64,
    parameter int IDLE_TIMEOUT = 1024
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NUM_REQ*DATA_BITS-1:0] req_data,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ-1:0]           req_last,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [DATA_BITS-1:0]         tx_data,
    output logic                         tx_valid,
    input  logic                         tx_ready,
    output logic [NUM_REQ-1:0]           grant,
    output logic                         busy,
    output logic                         forced_rel
);

    localparam int IW     = $clog2(NUM_REQ);
    localparam int CNT_W  = $clog2(MAX_LEN + 1);
    localparam int IDLE_W = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;

    arb_state_e          state_q;
    logic [IW-1:0]       ptr_q;
    logic [IW-1:0]       idx_q;
    logic [NUM_REQ-1:0]  grant_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [IDLE_W-1:0]   idle_q;
    logic                forced_q;

    logic [NUM_REQ-1:0]   pick_win;
    logic [IW-1:0]        pick_idx;
    logic [DATA_BITS-1:0] lane [NUM_REQ];

    logic lock, g_valid, g_last, xfer;
    logic rel_last, rel_max, rel_idle;

    rr_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_pick (
        .req_i     (req_valid),
        .ptr_i     (ptr_q),
        .win_o     (pick_win),
        .win_idx_o (pick_idx)
    );

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            lane[i] = req_data[i*DATA_BITS +: DATA_BITS];
        end
    end

    assign lock    = (state_q == ST_LOCK);
    assign g_valid = lock & req_valid[idx_q];
    assign g_last  = req_last[idx_q];
    assign xfer    = g_valid & tx_ready;

    // A last byte wins over MAX_LEN so a message that ends exactly at the limit is not flagged
    assign rel_last = xfer & g_last;
    assign rel_max  = xfer & ~g_last & (cnt_q == CNT_W'(MAX_LEN - 1));
    assign rel_idle = lock & ~req_valid[idx_q] & (idle_q == IDLE_W'(IDLE_TIMEOUT - 1));

    assign tx_valid   = g_valid;
    assign tx_data    = lock ? lane[idx_q] : '0;
    assign req_ready  = grant_q & {NUM_REQ{tx_ready}};
    assign grant      = grant_q;
    assign busy       = lock;
    assign forced_rel = forced_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_ARB;
            ptr_q    <= IW'(NUM_REQ - 1);
            idx_q    <= '0;
            grant_q  <= '0;
            cnt_q    <= '0;
            idle_q   <= '0;
            forced_q <= 1'b0;
        end else begin
            forced_q <= 1'b0;
            case (state_q)
                ST_ARB: begin
                    if (|req_valid) begin
                        grant_q <= pick_win;
                        idx_q   <= pick_idx;
                        cnt_q   <= '0;
                        idle_q  <= '0;
                        state_q <= ST_LOCK;
                    end
                end
                ST_LOCK: begin
                    if (xfer) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                    if (req_valid[idx_q]) begin
                        idle_q <= '0;
                    end else begin
                        idle_q <= idle_q + IDLE_W'(1);
                    end
                    if (rel_last || rel_max || rel_idle) begin
                        state_q  <= ST_ARB;
                        grant_q  <= '0;
                        ptr_q    <= idx_q;
                        forced_q <= rel_max | rel_idle;
                    end
                end
                default: state_q <= ST_ARB;
            endcase
        end
    end

endmodule

// File: doc/uart_tx_arb.md
# uart_tx_arb

Round-robin arbiter that shares the single UART transmitter among `NUM_REQ` byte-stream requesters (status reporter, debug console, time-readout, etc.). It grants the transmitter for one whole message, delimited by a `last` flag, so bytes from different requesters never interleave on `txd`. It sits directly in front of the transmitter's valid/ready byte port and adds no buffering.

## Interface
- `NUM_REQ`, 4: number of requesters; at least 2.
- `DATA_BITS`, 8: byte width; matches the transmitter.
- `MAX_LEN`, 64: maximum bytes per grant; a forced release occurs after this many.
- `IDLE_TIMEOUT`, 1024: number of consecutive clocks without `req_valid` from the granted requester before a forced release.
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous active-low reset.
- `req_data` in `NUM_REQ*DATA_BITS`: requester i's data in bits `[i*DATA_BITS +: DATA_BITS]`.
- `req_valid` in `NUM_REQ`: per-requester byte valid.
- `req_last` in `NUM_REQ`: marks the final byte of a message; qualified by valid.
- `req_ready` out `NUM_REQ`: per-requester byte accepted.
- `tx_data` out `DATA_BITS`: to the transmitter.
- `tx_valid` out 1: to the transmitter.
- `tx_ready` in 1: from the transmitter; high only when the transmitter is idle.
- `grant` out `NUM_REQ`: one-hot current owner; all zero when unowned.
- `busy` out 1: high while a grant is held.
- `forced_rel` out 1: one-cycle pulse on a MAX_LEN or timeout release.

## Operation
- States: ST_ARB and ST_LOCK.
- ST_ARB: if any `req_valid` is high, pick the first requester with valid high, scanning from `ptr+1` upward modulo `NUM_REQ`. Register it into `grant` and go to ST_LOCK. Reset the byte count and idle counter.
- ST_LOCK datapath is combinational on the registered grant:
  - `tx_data` = granted requester's data.
  - `tx_valid` = granted requester's `req_valid`.
  - `req_ready[g]` = `tx_ready`.
  - All other `req_ready` bits are 0.
- A transfer is `tx_valid & tx_ready`. On each transfer the byte count increments.
- Release from ST_LOCK to ST_ARB happens on the clock edge after any of these:
  - a transfer with `req_last[g]` set (normal release);
  - a transfer that is byte number `MAX_LEN` (forced);
  - the idle counter reaching `IDLE_TIMEOUT-1` while the granted requester's valid is low (forced).
- On release: `ptr` is set to g, `grant` is cleared, and `busy` falls. `forced_rel` pulses for forced releases only.
- Idle counter: increments each ST_LOCK cycle in which the granted requester's valid is low. It clears on any cycle with valid high.
- Requester valid dropping mid-message does not release the grant; only the timeout does.
- Simultaneous release conditions: a last-byte transfer that is also byte `MAX_LEN` counts as a normal release, so `forced_rel` stays 0.
- Non-granted requesters holding valid are never dropped. They win in round-robin order.
- Reset: state ST_ARB, `ptr` = `NUM_REQ-1` so requester 0 has first priority, `grant` = 0, counters = 0, `forced_rel` = 0. Consequently `tx_valid`, `req_ready` and `busy` are all 0.
- Assertion of `reset_n` mid-message abandons the message immediately. The transmitter's own reset handles the serial line.

## Timing
- Arbitration latency: with ST_ARB and a valid pending at edge k, `grant` and `busy` are high after edge k, and `tx_valid` is high in the same cycle.
- Transfer timing follows the transmitter's handshake: one byte is accepted per `tx_ready` pulse, and back-to-back bytes are limited by the UART frame time.
- Release to next grant: a minimum of 1 cycle in ST_ARB between messages, so `grant` is zero for exactly one cycle.
- Byte counter width: `$clog2(MAX_LEN+1)`. Idle counter width: `$clog2(IDLE_TIMEOUT)`. Both are saturation-free because they are cleared on grant.
- All outputs are glitch-free registered functions of `grant`, `state` and the inputs. No combinational path exists from `tx_ready` to `tx_valid`.

## Structure
- Shared package holds the state encodings ST_ARB and ST_LOCK and the default `DATA_BITS`, which is shared with the transmitter.
- One sub-module, `rr_pick`: a combinational round-robin picker. Inputs are the `NUM_REQ` request bits and `ptr`. Outputs are a one-hot winner and its index. It is reusable for other shared resources.

## Test plan
- **Single requester:** req 2 sends 0x48, 0x49 (with last) → both bytes appear on `tx_data` in order; `grant` = 0100 then 0000; `forced_rel` stays 0.
- **Contention after reset:** req 0 and req 3 are valid simultaneously → req 0 is served first. After its last byte, req 3 is granted following exactly one zero-grant cycle.
- **Fairness:** all 4 requesters continuously send 1-byte messages → the grant order is 0, 1, 2, 3, 0, … with no requester served twice in a row.
- **MAX_LEN=4:** a requester sends 6 bytes without last → release after the 4th transfer, `forced_rel` pulses once, and bytes 5 and 6 are sent under the next grant.
- **IDLE_TIMEOUT=8:** the granted requester drops valid after byte 1 → release after 8 idle cycles with `forced_rel` = 1; another pending requester is granted next.
- **Reset mid-message:** `reset_n` is pulled low while `tx_valid` = 1 → `grant`, `tx_valid`, `req_ready`, `busy` and `forced_rel` go to 0 immediately, with no clock required.
